vector_mem_sequencer: RTL and testbench

- Memory-stage consumer of the EX/MEM pipeline register outputs.
- Executes one vector (R lanes) or scalar (lane 0) load/store against a byte-wide data memory, one lane per handshake.
- Holds the pipeline via StallM until all lanes complete.
- Returns assembled load data toward the MEM/WB register.

---
 rtl/vmem_pkg.sv | 19 +
 rtl/vmem_lane_counter.sv | 31 +++
 rtl/vector_mem_sequencer.sv | 168 ++++++++++++++++
 tb/tb_vector_mem_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared types and defaults for the vector memory sequencer.
// The optional watchdog is built in when VMEM_TIMEOUT_EN is defined.
package vmem_pkg;

    // Sequencer states: wait for an op, walk the lanes, signal completion.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } vmem_state_e;

    // Default geometry and watchdog limit.
    localparam int DEF_R       = 6;
    localparam int DEF_TIMEOUT = 64;

    // Lane index for the default lane count.
    typedef logic [$clog2(DEF_R)-1:0] lane_t;

endpackage

// File: rtl/vmem_lane_counter.sv
// Lane index register for the vector memory sequencer.
// Cleared when an access starts, stepped once per completed lane,
// and compared against the latched last-lane index.
module vmem_lane_counter #(
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    input  logic [LW-1:0] last,
    output logic [LW-1:0] lane,
    output logic [LW-1:0] lane_nxt,
    output logic          at_last
);

    assign lane_nxt = lane + 1'b1;
    assign at_last  = (lane == last);

    // Lane register: clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane <= '0;
        end else if (clr) begin
            lane <= '0;
        end else if (inc) begin
            lane <= lane_nxt;
        end
    end

endmodule

// File: rtl/vector_mem_sequencer.sv
// Memory-stage sequencer: runs a vector (R lanes) or scalar (lane 0)
// load/store against a byte-wide memory, one lane per handshake, and
// stalls the pipeline until the access completes.
// Define VMEM_TIMEOUT_EN to add the stuck-memory watchdog (MemErrM).
module vector_mem_sequencer
    import vmem_pkg::*;
#(
    parameter int I       = 32,
    parameter int N       = 8,
    parameter int R       = DEF_R,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           MemWriteM,
    input  logic           MemtoRegM,
    input  logic           LDSFlagM,
    input  logic [I-1:0]   AddressM,
    input  logic [R*N-1:0] WriteDataM,
    output logic           mem_req,
    output logic           mem_we,
    output logic [I-1:0]   mem_addr,
    output logic [N-1:0]   mem_wdata,
    input  logic           mem_ready,
    input  logic [N-1:0]   mem_rdata,
    output logic [R*N-1:0] ReadDataM,
    output logic           StallM,
    output logic           DoneM,
    output logic           MemErrM,
    output logic [1:0]     state_dbg
);

    localparam int            LW       = (R > 1) ? $clog2(R) : 1;
    localparam logic [LW-1:0] LANE_MAX = LW'(R - 1);

    // Memory handshake: a lane transfer happens on a rising edge where
    // mem_req=1 and mem_ready=1. While mem_req=1 and mem_ready=0 the
    // request (mem_we, mem_addr, mem_wdata) is held unchanged. mem_req
    // never drops before its lane has been accepted, except on reset or
    // watchdog abort.

    vmem_state_e    state;
    logic [I-1:0]   base_q;
    logic [R*N-1:0] wdata_q;
    logic [LW-1:0]  last_q;
    logic [LW-1:0]  lane;
    logic [LW-1:0]  lane_nxt;
    logic           at_last;
    logic           op;
    logic           abort;

    assign op        = MemWriteM | MemtoRegM;
    assign state_dbg = state;

    // Held in reset the pipeline must not stall, even with an op pending.
    assign StallM = reset & (((state == IDLE) & op) | (state == ACCESS));

    vmem_lane_counter #(.LW(LW)) u_lane (
        .clk      (clk),
        .reset    (reset),
        .clr      ((state == IDLE) & op),
        .inc      ((state == ACCESS) & mem_ready & ~at_last),
        .last     (last_q),
        .lane     (lane),
        .lane_nxt (lane_nxt),
        .at_last  (at_last)
    );

`ifdef VMEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    // Abort on the TIMEOUT-th consecutive cycle without mem_ready.
    assign abort   = (state == ACCESS) & ~mem_ready & (tmo_cnt == TW'(TIMEOUT - 1));
    assign MemErrM = err_q;

    // Watchdog: counts stalled request cycles, restarts on every acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if ((state == ACCESS) && !mem_ready && !abort) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT > 0);
    assign abort          = 1'b0;
    assign MemErrM        = 1'b0;
`endif

    // Sequencer FSM with registered request, load data and done outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            base_q    <= '0;
            wdata_q   <= '0;
            last_q    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ReadDataM <= '0;
            DoneM     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op) begin
                        base_q    <= AddressM;
                        wdata_q   <= WriteDataM;
                        last_q    <= LDSFlagM ? '0 : LANE_MAX;
                        // A store wins over a simultaneous load.
                        if (!MemWriteM) begin
                            ReadDataM <= '0;
                        end
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteM;
                        mem_addr  <= AddressM;
                        mem_wdata <= WriteDataM[N-1:0];
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            ReadDataM[int'(lane)*N +: N] <= mem_rdata;
                        end
                        if (at_last) begin
                            mem_req <= 1'b0;
                            DoneM   <= 1'b1;
                            state   <= DONE;
                        end else begin
                            // Address wraps modulo 2^I.
                            mem_addr  <= base_q + {{(I-LW){1'b0}}, lane_nxt};
                            mem_wdata <= wdata_q[int'(lane_nxt)*N +: N];
                        end
                    end else if (abort) begin
                        mem_req <= 1'b0;
                        DoneM   <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    DoneM <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Testbench for vector_mem_sequencer: directed ops with hand-computed
// lane beats and load results, checked by a decoupled monitor.
module tb_vector_mem_sequencer;
    import vmem_pkg::*;

    localparam int BW = 1 + 32 + 8;
    localparam int DW = 1 + 48;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic        MemtoRegM;
    logic        LDSFlagM;
    logic [31:0] AddressM;
    logic [47:0] WriteDataM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic [47:0] ReadDataM;
    logic        StallM;
    logic        DoneM;
    logic        MemErrM;
    logic [1:0]  state_dbg;

    logic [7:0]  mem_ram [256];

    logic [BW-1:0] exp_beat_q[$];
    logic [DW-1:0] exp_done_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    vector_mem_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .LDSFlagM   (LDSFlagM),
        .AddressM   (AddressM),
        .WriteDataM (WriteDataM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .DoneM      (DoneM),
        .MemErrM    (MemErrM),
        .state_dbg  (state_dbg)
    );

    assign mem_rdata = mem_ram[mem_addr[7:0]];

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_beats(input logic we, input logic [31:0] addr, input logic [47:0] wd,
                              input int n);
        for (int k = 0; k < n; k++) begin
            exp_beat_q.push_back({we, addr + 32'(k), wd[k*8 +: 8]});
        end
    endtask

    task automatic push_done(input logic err, input logic [47:0] rd);
        exp_done_q.push_back({err, rd});
    endtask

    // Driver: issue one op, steer mem_ready, check stall and done timing.
    task automatic run_op(input logic we, input logic re, input logic sc,
                          input logic [31:0] addr, input logic [47:0] wd,
                          input int stall_lane, input int stall_cycles, input int exp_lat);
        int cyc;
        int beats;
        int stalls;
        bit done;
        @(negedge clk);
        MemWriteM  = we;
        MemtoRegM  = re;
        LDSFlagM   = sc;
        AddressM   = addr;
        WriteDataM = wd;
        mem_ready  = 1'b1;
        #1;
        check("stall_on_issue", 64'(StallM), 64'(1));
        cyc    = 0;
        beats  = 0;
        stalls = 0;
        done   = 1'b0;
        while (!done && cyc < exp_lat + 20) begin
            @(negedge clk);
            cyc++;
            if (DoneM) begin
                done = 1'b1;
                check("done_cycle", 64'(cyc), 64'(exp_lat));
                check("stall_in_done", 64'(StallM), 64'(0));
                MemWriteM = 1'b0;
                MemtoRegM = 1'b0;
            end else begin
                check("stall_busy", 64'(StallM), 64'(1));
                if (mem_req) begin
                    if (beats == stall_lane && stalls < stall_cycles) begin
                        if (stalls > 0) begin
                            check("hold_addr", 64'(mem_addr), 64'(addr + 32'(stall_lane)));
                            check("hold_wdata", 64'(mem_wdata),
                                  64'(we ? wd[stall_lane*8 +: 8] : 8'h00));
                        end
                        mem_ready = 1'b0;
                        stalls++;
                    end else begin
                        mem_ready = 1'b1;
                        beats++;
                    end
                end
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_wait: no DoneM within %0d cycles, expected at %0d", cyc, exp_lat);
            MemWriteM = 1'b0;
            MemtoRegM = 1'b0;
        end
        @(negedge clk);
        check("done_one_cycle", 64'(DoneM), 64'(0));
        mem_ready = 1'b1;
    endtask

    // Monitor / scoreboard: every accepted lane and every done pulse is
    // popped against the expected queues; stores update the memory model.
    initial begin
        logic [BW-1:0] eb;
        logic [DW-1:0] ed;
        for (int i = 0; i < 256; i++) mem_ram[i] = 8'h00;
        for (int i = 0; i < 6; i++) mem_ram[i] = 8'(8'h11 * (i + 1));
        forever begin
            @(negedge clk);
            #3;
            if (mem_req && mem_ready) begin
                if (exp_beat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got we=%0b addr=%h data=%h, expected none",
                             mem_we, mem_addr, mem_wdata);
                end else begin
                    eb = exp_beat_q.pop_front();
                    check("beat", 64'({mem_we, mem_addr, mem_wdata}), 64'(eb));
                end
                if (mem_we) mem_ram[mem_addr[7:0]] = mem_wdata;
            end
            if (DoneM) begin
                if (exp_done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_unexpected: got DoneM=1, expected none");
                end else begin
                    ed = exp_done_q.pop_front();
                    check("done_result", 64'({MemErrM, ReadDataM}), 64'(ed));
                end
            end
        end
    end

    // Stimulus
    initial begin
        reset      = 1'b0;
        MemWriteM  = 1'b0;
        MemtoRegM  = 1'b0;
        LDSFlagM   = 1'b0;
        AddressM   = '0;
        WriteDataM = '0;
        mem_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_readdata", 64'(ReadDataM), 64'(0));
        check("rst_done", 64'(DoneM), 64'(0));
        check("rst_err", 64'(MemErrM), 64'(0));
        check("rst_stall", 64'(StallM), 64'(0));
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        reset = 1'b1;

        // Vector load from 0x100 (model index 0..5 holds 11..66).
        push_beats(1'b0, 32'h100, 48'h0, 6);
        push_done(1'b0, 48'h665544332211);
        run_op(1'b0, 1'b1, 1'b0, 32'h100, 48'h0, -1, 0, 7);

        // Scalar store: only lane 0 goes out; load data untouched.
        push_beats(1'b1, 32'h20, 48'h0102030405A5, 1);
        push_done(1'b0, 48'h665544332211);
        run_op(1'b1, 1'b0, 1'b1, 32'h20, 48'h0102030405A5, -1, 0, 2);

        // Vector store wrapping through the top of the address space.
        exp_beat_q.push_back({1'b1, 32'hFFFF_FFFE, 8'hF1});
        exp_beat_q.push_back({1'b1, 32'hFFFF_FFFF, 8'hF2});
        exp_beat_q.push_back({1'b1, 32'h0000_0000, 8'hF3});
        exp_beat_q.push_back({1'b1, 32'h0000_0001, 8'hF4});
        exp_beat_q.push_back({1'b1, 32'h0000_0002, 8'hF5});
        exp_beat_q.push_back({1'b1, 32'h0000_0003, 8'hF6});
        push_done(1'b0, 48'h665544332211);
        run_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 48'hF6F5F4F3F2F1, -1, 0, 7);

        // Store and load together: the store wins, no load capture.
        push_beats(1'b1, 32'h40, 48'hC6C5C4C3C2C1, 6);
        push_done(1'b0, 48'h665544332211);
        run_op(1'b1, 1'b1, 1'b0, 32'h40, 48'hC6C5C4C3C2C1, -1, 0, 7);

        // Back-pressure: three wait cycles on lane 2 of a vector load.
        push_beats(1'b0, 32'h40, 48'h0, 6);
        push_done(1'b0, 48'hC6C5C4C3C2C1);
        run_op(1'b0, 1'b1, 1'b0, 32'h40, 48'h0, 2, 3, 10);

        // Scalar load: untouched lanes read back as zero.
        push_beats(1'b0, 32'h20, 48'h0, 1);
        push_done(1'b0, 48'h0000000000A5);
        run_op(1'b0, 1'b1, 1'b1, 32'h20, 48'h0, -1, 0, 2);

        // Reset during lane 3 of a vector load.
        push_beats(1'b0, 32'h40, 48'h0, 3);
        @(negedge clk);
        MemWriteM  = 1'b0;
        MemtoRegM  = 1'b1;
        LDSFlagM   = 1'b0;
        AddressM   = 32'h40;
        WriteDataM = 48'h0;
        repeat (4) @(negedge clk);
        check("mid_lane3_addr", 64'(mem_addr), 64'(32'h43));
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_req", 64'(mem_req), 64'(0));
        check("mid_rst_stall", 64'(StallM), 64'(0));
        check("mid_rst_readdata", 64'(ReadDataM), 64'(0));
        MemtoRegM = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // After the abort the next op starts again at lane 0.
        push_beats(1'b1, 32'h50, 48'h00000000005A, 1);
        push_done(1'b0, 48'h0);
        run_op(1'b1, 1'b0, 1'b1, 32'h50, 48'h00000000005A, -1, 0, 2);
        push_beats(1'b0, 32'h50, 48'h0, 1);
        push_done(1'b0, 48'h00000000005A);
        run_op(1'b0, 1'b1, 1'b1, 32'h50, 48'h0, -1, 0, 2);

`ifdef VMEM_TIMEOUT_EN
        // Memory never answers: watchdog aborts after 64 stalled cycles.
        push_done(1'b1, 48'h0);
        run_op(1'b0, 1'b1, 1'b0, 32'h60, 48'h0, 0, 1000, 65);
        repeat (5) @(negedge clk);
        check("err_sticky", 64'(MemErrM), 64'(1));
        reset = 1'b0;
        #1;
        check("err_cleared_by_reset", 64'(MemErrM), 64'(0));
        @(negedge clk);
        reset = 1'b1;
`endif

        repeat (3) @(negedge clk);
        check("beats_drained", 64'(exp_beat_q.size()), 64'(0));
        check("dones_drained", 64'(exp_done_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
